// File: rtl/pc_fetch_pkg.sv
// Shared types for the PC fetch sequencer: FSM state encoding, redirect kinds
// and default sizing.
package pc_fetch_pkg;

    localparam int AWIDTH_DEF    = 6;
    localparam int RESET_VEC_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_BR   = 2'b01,
        RD_JMP  = 2'b10
    } redir_t;

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_sel.sv
// Next-PC selection: resolves this cycle's redirect (jmp over branch), then picks
// the newest redirect over the pending one over pc+1. Purely combinational.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic [AWIDTH-1:0] pc,
    input  logic              capture_en,
    input  logic              br_taken,
    input  logic [AWIDTH-1:0] br_off,
    input  logic              jmp,
    input  logic [AWIDTH-1:0] jmp_addr,
    input  redir_t            pend_kind,
    input  logic [AWIDTH-1:0] pend_tgt,
    output redir_t            new_kind,
    output logic [AWIDTH-1:0] new_tgt,
    output logic              redirect,
    output logic [AWIDTH-1:0] next_pc
);

    always_comb begin
        new_kind = RD_NONE;
        new_tgt  = pc + br_off;
        if (capture_en) begin
            if (jmp) begin
                new_kind = RD_JMP;
                new_tgt  = jmp_addr;
            end else if (br_taken) begin
                new_kind = RD_BR;
            end
        end

        // A redirect arriving this cycle is newer than anything pending.
        redirect = 1'b1;
        if (new_kind != RD_NONE) begin
            next_pc = new_tgt;
        end else if (pend_kind != RD_NONE) begin
            next_pc = pend_tgt;
        end else begin
            redirect = 1'b0;
            next_pc  = pc + AWIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem request per instruction, holds it
// until ack, and tracks pending redirects (squashing the fetch they overtake) and halt.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int RESET_VEC = RESET_VEC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [AWIDTH-1:0] br_off,
    input  logic              jmp,
    input  logic [AWIDTH-1:0] jmp_addr,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_valid,
    output logic [AWIDTH-1:0] pc,
    output logic [1:0]        state
);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    redir_t            pend_kind_q, pend_kind_d;
    logic [AWIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic              halt_q, halt_d;
    logic              instr_valid_q, instr_valid_d;

    logic              req_c;
    logic              done_c;
    logic              halt_pend_c;
    redir_t            new_kind;
    logic [AWIDTH-1:0] new_tgt;
    logic              redirect;
    logic [AWIDTH-1:0] next_pc;

    pc_next_sel #(.AWIDTH(AWIDTH)) u_next_sel (
        .pc         (pc_q),
        .capture_en (state_q != ST_HALT),
        .br_taken   (br_taken),
        .br_off     (br_off),
        .jmp        (jmp),
        .jmp_addr   (jmp_addr),
        .pend_kind  (pend_kind_q),
        .pend_tgt   (pend_tgt_q),
        .new_kind   (new_kind),
        .new_tgt    (new_tgt),
        .redirect   (redirect),
        .next_pc    (next_pc)
    );

    // Once in WAIT the request is held regardless of stall.
    assign req_c       = ((state_q == ST_REQ) && !stall) || (state_q == ST_WAIT);
    assign done_c      = req_c && imem_ack;
    assign halt_pend_c = halt_q || halt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_kind_d   = pend_kind_q;
        pend_tgt_d    = pend_tgt_q;
        halt_d        = halt_pend_c;
        instr_valid_d = 1'b0;

        if (new_kind != RD_NONE) begin
            pend_kind_d = new_kind;
            pend_tgt_d  = new_tgt;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (halt_pend_c) begin
                    state_d = ST_HALT;
                end else if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_WAIT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Completion consumes any redirect and squashes the fetch it overtook.
        if (done_c) begin
            pc_d          = next_pc;
            pend_kind_d   = RD_NONE;
            instr_valid_d = !redirect;
            state_d       = halt_pend_c ? ST_HALT : ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= AWIDTH'(RESET_VEC);
            pend_kind_q   <= RD_NONE;
            pend_tgt_q    <= '0;
            halt_q        <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_kind_q   <= pend_kind_d;
            pend_tgt_q    <= pend_tgt_d;
            halt_q        <= halt_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stall = 1'b0, halt = 1'b0;
    logic       br_taken = 1'b0, jmp = 1'b0, imem_ack = 1'b0;
    logic [5:0] br_off = '0, jmp_addr = '0;
    logic       imem_req, instr_valid;
    logic [5:0] imem_addr, pc;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 requesting, 2 waiting, 3 halted.
    int m_pc    = 5;
    int m_state = 0;
    bit m_pend  = 0;
    int m_tgt   = 0;
    bit m_halt  = 0;
    bit m_valid = 0;

    pc_fetch_sequencer #(.AWIDTH(6), .RESET_VEC(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .br_taken    (br_taken),
        .br_off      (br_off),
        .jmp         (jmp),
        .jmp_addr    (jmp_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .pc          (pc),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit model_req();
        return (m_state == 1 && !stall) || m_state == 2;
    endfunction

    // Sample outputs mid-cycle and compare with the model.
    task automatic observe();
        @(negedge clk);
        chk("pc", int'(pc), m_pc);
        chk("imem_addr", int'(imem_addr), m_pc);
        chk("state", int'(state), m_state);
        chk("imem_req", int'(imem_req), int'(model_req()));
        chk("instr_valid", int'(instr_valid), int'(m_valid));
    endtask

    // Apply the rules for the coming edge to the model, then take the edge.
    task automatic advance();
        bit req, done, arrive, hp;
        int tgt;
        if (!rst) begin
            m_pc = 5; m_state = 0; m_pend = 0; m_halt = 0; m_valid = 0;
        end else begin
            req    = model_req();
            done   = req && imem_ack;
            arrive = (m_state != 3) && (jmp || br_taken);
            tgt    = jmp ? int'(jmp_addr) : (m_pc + int'(br_off)) % 64;
            hp     = m_halt || halt;
            m_valid = done && !(arrive || m_pend);
            if (done) begin
                m_pc    = arrive ? tgt : (m_pend ? m_tgt : (m_pc + 1) % 64);
                m_pend  = 0;
                m_state = hp ? 3 : 1;
            end else begin
                if (arrive) begin
                    m_pend = 1;
                    m_tgt  = tgt;
                end
                case (m_state)
                    0: if (hp) m_state = 3; else if (start) m_state = 1;
                    1: if (!stall) m_state = 2;
                    default: ;
                endcase
            end
            m_halt = hp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        observe();
        advance();
    endtask

    initial begin
        // Reset held two cycles.
        advance();
        advance();
        rst = 1'b1;
        observe();
        chk("rst_pc", int'(pc), 5);
        chk("rst_state", int'(state), 0);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_valid", int'(instr_valid), 0);

        // Zero-wait sequential fetch: 5,6,7,8.
        start = 1'b1; imem_ack = 1'b1;
        advance();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            observe();
            chk("seq_addr", int'(imem_addr), 5 + i);
            chk("seq_req", int'(imem_req), 1);
            if (i > 0) chk("seq_valid", int'(instr_valid), 1);
            advance();
        end

        // Jump to 62 via WAIT, then wrap 62,63,0,1.
        jmp = 1'b1; jmp_addr = 6'd62; imem_ack = 1'b0;
        cyc();
        jmp = 1'b0; imem_ack = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            observe();
            chk("wrap_addr", int'(imem_addr), (62 + i) % 64);
            if (i == 0) chk("wrap_squash", int'(instr_valid), 0);
            advance();
        end

        // Three-cycle ack delay, jump to 20 during WAIT squashes the fetch.
        imem_ack = 1'b0;
        cyc();
        jmp = 1'b1; jmp_addr = 6'd20;
        cyc();
        jmp = 1'b0;
        cyc();
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        observe();
        chk("jmpwait_valid", int'(instr_valid), 0);
        chk("jmpwait_addr", int'(imem_addr), 20);
        chk("jmpwait_state", int'(state), 1);
        imem_ack = 1'b1; jmp = 1'b1; jmp_addr = 6'd10;
        advance();
        jmp = 1'b0;

        // Branch -3 from 10 lands on 7.
        br_taken = 1'b1; br_off = 6'h3D;
        observe();
        chk("br_from", int'(imem_addr), 10);
        advance();
        br_taken = 1'b0;
        observe();
        chk("br_addr", int'(imem_addr), 7);
        chk("br_squash", int'(instr_valid), 0);
        jmp = 1'b1; jmp_addr = 6'd10;
        advance();
        jmp = 1'b0;

        // Branch and jump together: jump wins.
        br_taken = 1'b1; br_off = 6'h3D; jmp = 1'b1; jmp_addr = 6'd40;
        cyc();
        br_taken = 1'b0; jmp = 1'b0;
        observe();
        chk("jmpwin_addr", int'(imem_addr), 40);
        advance();

        // Stall in REQ for four cycles, then halt during WAIT.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            observe();
            chk("stall_req", int'(imem_req), 0);
            chk("stall_pc", int'(pc), 41);
            advance();
        end
        stall = 1'b0; imem_ack = 1'b0;
        observe();
        chk("unstall_req", int'(imem_req), 1);
        advance();
        halt = 1'b1;
        cyc();
        halt = 1'b0; imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0; start = 1'b1; jmp = 1'b1; jmp_addr = 6'd3;
        observe();
        chk("halt_valid", int'(instr_valid), 1);
        chk("halt_state", int'(state), 3);
        chk("halt_req", int'(imem_req), 0);
        chk("halt_pc", int'(pc), 42);
        advance();
        start = 1'b0; jmp = 1'b0;
        observe();
        chk("halt_hold", int'(state), 3);
        chk("halt_valid_end", int'(instr_valid), 0);
        advance();

        // Reset mid-WAIT with an ack in the reset cycle.
        rst = 1'b0;
        advance();
        rst = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b0; imem_ack = 1'b1;
        cyc();
        rst = 1'b1; imem_ack = 1'b0;
        observe();
        chk("midrst_pc", int'(pc), 5);
        chk("midrst_state", int'(state), 0);
        chk("midrst_valid", int'(instr_valid), 0);
        chk("midrst_req", int'(imem_req), 0);
        advance();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 39) != 0);
            start    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            halt     = ($urandom_range(0, 49) == 0);
            br_taken = ($urandom_range(0, 9) == 0);
            jmp      = ($urandom_range(0, 15) == 0);
            br_off   = 6'($urandom_range(0, 63));
            jmp_addr = 6'($urandom_range(0, 63));
            imem_ack = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
